// File: rtl/sample_packer_if.sv
// Sample/word handshake bundle between the serial channel source, the packer
// and the parallel FFE input bus.
interface sample_packer_if #(
    parameter int unsigned NB_IN       = 18,
    parameter int unsigned PARALLELISM = 8,
    parameter int unsigned NB_WCNT     = 32
);
    logic                         i_en;
    logic                         i_valid;
    logic                         o_ready;
    logic [NB_IN-1:0]             i_sample;
    logic                         i_flush;
    logic                         o_valid;
    logic                         i_ready;
    logic [PARALLELISM*NB_IN-1:0] o_sample;
    logic                         o_last;
    logic [NB_WCNT-1:0]           o_words;

    modport master (
        output i_en, i_valid, i_sample, i_flush, i_ready,
        input  o_ready, o_valid, o_sample, o_last, o_words
    );

    modport slave (
        input  i_en, i_valid, i_sample, i_flush, i_ready,
        output o_ready, o_valid, o_sample, o_last, o_words
    );
endinterface

// File: rtl/sample_packer.sv
// Packs PARALLELISM serial samples (oldest at lane 0) into one word and hands
// it to the parallel FFE through a 2-entry output buffer; flush zero-pads.
module sample_packer #(
    parameter int unsigned NB_IN       = 18,
    parameter int unsigned PARALLELISM = 8,
    parameter int unsigned NB_WCNT     = 32
) (
    input logic            clk,
    input logic            rst,
    sample_packer_if.slave bus
);
    localparam int unsigned CW = $clog2(PARALLELISM);
    localparam int unsigned WW = PARALLELISM * NB_IN;

    logic [CW-1:0]      cnt_q, cnt_d;
    logic [WW-1:0]      stage_q, stage_d;
    logic [WW-1:0]      head0_q, head0_d, head1_q, head1_d;
    logic               last0_q, last0_d, last1_q, last1_d;
    logic [1:0]         occ_q, occ_d;
    logic [NB_WCNT-1:0] words_q, words_d;

    logic          ready, acc, flush_eff, push, pop;
    logic [WW-1:0] push_word;

    always_comb begin
        ready     = bus.i_en && (occ_q != 2'd2);
        acc       = bus.i_valid && ready;
        flush_eff = bus.i_flush && ready;
        pop       = (occ_q != 2'd0) && bus.i_ready;

        // Unwritten lanes stay zero because staging is cleared on every push.
        push_word = stage_q;
        for (int unsigned k = 0; k < PARALLELISM; k++) begin
            if (acc && (cnt_q == CW'(k))) begin
                push_word[k*NB_IN +: NB_IN] = bus.i_sample;
            end
        end

        push = (acc && (cnt_q == CW'(PARALLELISM - 1)))
            || (flush_eff && (acc || (cnt_q != '0)));

        cnt_d   = cnt_q;
        stage_d = stage_q;
        if (push) begin
            cnt_d   = '0;
            stage_d = '0;
        end else if (acc) begin
            cnt_d   = cnt_q + 1'b1;
            stage_d = push_word;
        end

        head0_d = head0_q;
        head1_d = head1_q;
        last0_d = last0_q;
        last1_d = last1_q;
        occ_d   = occ_q;
        words_d = words_q + {{(NB_WCNT-1){1'b0}}, pop};

        // Entry 0 is always the head; a pop shifts entry 1 forward.
        case ({push, pop})
            2'b10: begin
                if (occ_q == 2'd0) begin
                    head0_d = push_word;
                    last0_d = flush_eff;
                end else begin
                    head1_d = push_word;
                    last1_d = flush_eff;
                end
                occ_d = occ_q + 2'd1;
            end
            2'b01: begin
                head0_d = head1_q;
                last0_d = last1_q;
                occ_d   = occ_q - 2'd1;
            end
            2'b11: begin
                if (occ_q == 2'd1) begin
                    head0_d = push_word;
                    last0_d = flush_eff;
                end else begin
                    head0_d = head1_q;
                    last0_d = last1_q;
                    head1_d = push_word;
                    last1_d = flush_eff;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt_q   <= '0;
            stage_q <= '0;
            head0_q <= '0;
            head1_q <= '0;
            last0_q <= 1'b0;
            last1_q <= 1'b0;
            occ_q   <= '0;
            words_q <= '0;
        end else begin
            cnt_q   <= cnt_d;
            stage_q <= stage_d;
            head0_q <= head0_d;
            head1_q <= head1_d;
            last0_q <= last0_d;
            last1_q <= last1_d;
            occ_q   <= occ_d;
            words_q <= words_d;
        end
    end

    assign bus.o_ready  = bus.i_en && (occ_q != 2'd2);
    assign bus.o_valid  = (occ_q != 2'd0);
    assign bus.o_sample = head0_q;
    assign bus.o_last   = last0_q;
    assign bus.o_words  = words_q;
endmodule

// File: tb/tb_sample_packer.sv
// Scoreboard bench for sample_packer: a behavioural lane model queues expected
// words as samples are driven; words are checked as the DUT pops them.
module tb_sample_packer;
    localparam int NB_IN = 18;
    localparam int P     = 8;
    localparam int NW    = 32;
    localparam int WW    = P * NB_IN;

    typedef struct {
        logic [WW-1:0] word;
        logic          last;
    } exp_t;

    logic clk = 1'b0;
    logic rst;

    sample_packer_if #(.NB_IN(NB_IN), .PARALLELISM(P), .NB_WCNT(NW)) bus ();

    sample_packer #(.NB_IN(NB_IN), .PARALLELISM(P), .NB_WCNT(NW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    exp_t             exp_q[$];
    logic [NB_IN-1:0] mlane[P];
    int               mcnt;
    logic [NW-1:0]    mwords;
    int               n_cmp = 0;
    int               n_err = 0;
    bit               armed = 0;
    bit               last_acc;

    task automatic chk(input string tag, input logic [WW-1:0] got, input logic [WW-1:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // One clock: compare outputs at negedge, advance the model, step past posedge.
    task automatic cycle();
        logic          mready, acc, flush;
        logic [WW-1:0] w;
        @(negedge clk);
        mready = bus.i_en && (exp_q.size() < 2);
        if (armed) begin
            chk("o_ready", bus.o_ready, mready);
            chk("o_valid", bus.o_valid, exp_q.size() > 0);
            chk("o_words", bus.o_words, mwords);
            if (exp_q.size() > 0) begin
                chk("o_sample", bus.o_sample, exp_q[0].word);
                chk("o_last", bus.o_last, exp_q[0].last);
            end
        end
        last_acc = 1'b0;
        if (!rst) begin
            exp_q.delete();
            mcnt   = 0;
            mwords = '0;
        end else begin
            acc   = bus.i_valid && mready;
            flush = bus.i_flush && mready;
            if (exp_q.size() > 0 && bus.i_ready) begin
                void'(exp_q.pop_front());
                mwords++;
            end
            if (acc) begin
                mlane[mcnt] = bus.i_sample;
                mcnt++;
                last_acc = 1'b1;
            end
            if (mcnt == P || (flush && mcnt > 0)) begin
                w = '0;
                for (int k = 0; k < mcnt; k++) w[k*NB_IN +: NB_IN] = mlane[k];
                exp_q.push_back('{word: w, last: flush});
                mcnt = 0;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic send(input int n, input int base, input bit rnd);
        int               k = 0;
        int               budget = 0;
        logic [NB_IN-1:0] val;
        val = rnd ? NB_IN'($urandom) : NB_IN'(base);
        while (k < n && budget < 400) begin
            bus.i_valid  = 1'b1;
            bus.i_sample = val;
            cycle();
            budget++;
            if (last_acc) begin
                k++;
                val = rnd ? NB_IN'($urandom) : NB_IN'(base + k);
            end
        end
        bus.i_valid = 1'b0;
        if (k < n) chk("send_timeout", WW'(k), WW'(n));
    endtask

    task automatic drain();
        int n = 0;
        bus.i_ready = 1'b1;
        while (exp_q.size() > 0 && n < 50) begin
            cycle();
            n++;
        end
        if (exp_q.size() > 0) chk("drain_timeout", WW'(exp_q.size()), '0);
        cycle();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        bus.i_en     = 1'b1;
        bus.i_valid  = 1'b0;
        bus.i_sample = '0;
        bus.i_flush  = 1'b0;
        bus.i_ready  = 1'b1;
        rst          = 1'b0;
        mcnt         = 0;
        mwords       = '0;
        #1;
        cycle();
        cycle();
        chk("rst_valid", bus.o_valid, 1'b0);
        chk("rst_sample", bus.o_sample, '0);
        chk("rst_last", bus.o_last, 1'b0);
        chk("rst_words", bus.o_words, '0);
        chk("rst_ready", bus.o_ready, 1'b1);
        rst   = 1'b1;
        armed = 1'b1;

        // 1: two back-to-back words, immediate pop
        send(16, 1, 1'b0);
        drain();
        chk("t1_words", bus.o_words, WW'(2));

        // 2: backpressure fills the buffer, then release
        bus.i_ready = 1'b0;
        send(16, 1, 1'b0);
        bus.i_valid = 1'b1;
        cycle();
        chk("t2_ready_low", bus.o_ready, 1'b0);
        bus.i_valid = 1'b0;
        bus.i_ready = 1'b1;
        send(8, 17, 1'b0);
        drain();

        // 3: partial word closed by flush, then a full word
        send(1, -1, 1'b0);
        send(1, 5, 1'b0);
        send(1, -7, 1'b0);
        bus.i_flush = 1'b1;
        cycle();
        bus.i_flush = 1'b0;
        chk("t3_last", bus.o_last, 1'b1);
        chk("t3_word", bus.o_sample, {{(5*NB_IN){1'b0}}, 18'h3FFF9, 18'h00005, 18'h3FFFF});
        send(8, 100, 1'b0);
        drain();

        // 4: push and pop in the same cycle at occ==1, then flush on empty staging
        bus.i_ready = 1'b0;
        send(8, 200, 1'b0);
        send(7, 208, 1'b0);
        bus.i_ready = 1'b1;
        send(1, 215, 1'b0);
        chk("t4_occ1_valid", bus.o_valid, 1'b1);
        drain();
        bus.i_flush = 1'b1;
        cycle();
        bus.i_flush = 1'b0;
        idle(3);
        chk("t4_noword", bus.o_valid, 1'b0);

        // 5: reset with a buffered word and a partial word
        bus.i_ready = 1'b0;
        send(8, 300, 1'b0);
        send(5, 308, 1'b0);
        rst = 1'b0;
        cycle();
        rst = 1'b1;
        chk("t5_valid", bus.o_valid, 1'b0);
        chk("t5_words", bus.o_words, '0);
        bus.i_ready = 1'b1;
        send(8, 400, 1'b0);
        drain();

        // 6: enable dropped mid-word with valid still asserted
        send(4, 0, 1'b1);
        bus.i_en    = 1'b0;
        bus.i_valid = 1'b1;
        idle(10);
        bus.i_valid = 1'b0;
        bus.i_en    = 1'b1;
        send(4, 0, 1'b1);
        drain();
        send(8, 0, 1'b1);
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
